// File: rtl/blastit_uart_rx_if.sv
// Receive-side byte stream of blastit_uart_rx: valid/ready byte handshake plus one-cycle error pulses.
// The master (receiver) drives data, valid and errors; the slave (controller fabric) drives ready.
`timescale 1ns/1ps
interface blastit_uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output parity_err,
    output overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  parity_err,
    input  overrun,
    output rx_ready
  );
endinterface

// File: rtl/blastit_uart_rx.sv
// UART receiver, 8N1 (8E1 when BLASTIT_UART_RX_PARITY_EN is defined): byte valid 3+HALF+9*CLKS_PER_BIT cycles after the start edge (+CLKS_PER_BIT with parity).
// Single-entry holding register; a byte finishing while it is full and not draining is dropped with an overrun pulse.
`timescale 1ns/1ps
module blastit_uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic              clock_50_clk,
  input  logic              reset_reset,
  input  logic              uart_rx,
  blastit_uart_rx_if.master rx_if
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam int            HALF     = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

  typedef enum logic [2:0] {
    ST_WAIT_IDLE,
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    sync_q, sync_d;
  logic          rx_s;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          parity_err_q, parity_err_d;
  logic          overrun_q, overrun_d;
  logic          stop_sample;
  logic          par_bad;
  logic          deliver;

  assign sync_d = {sync_q[0], uart_rx};
  assign rx_s   = sync_q[1];

`ifdef BLASTIT_UART_RX_PARITY_EN
  logic par_bit_q, par_bit_d;
  // Even parity: data bits together with the parity bit must XOR to zero.
  assign par_bad = (^shift_q) ^ par_bit_q;
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge clock_50_clk) begin
    if (reset_reset) begin
      state_q      <= ST_WAIT_IDLE;
      sync_q       <= 2'b11;
      cnt_q        <= '0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'h00;
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef BLASTIT_UART_RX_PARITY_EN
      par_bit_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
`ifdef BLASTIT_UART_RX_PARITY_EN
      par_bit_q    <= par_bit_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    stop_sample = 1'b0;
`ifdef BLASTIT_UART_RX_PARITY_EN
    par_bit_d   = par_bit_q;
`endif
    case (state_q)
      ST_WAIT_IDLE: begin
        cnt_d = '0;
        if (rx_s) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = ST_START;
      end
      ST_START: begin
        // Re-check the line mid start bit so short low glitches are ignored.
        if (cnt_q == CNT_HALF) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          state_d   = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef BLASTIT_UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef BLASTIT_UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          par_bit_d = rx_s;
          state_d   = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        // Leaving at mid stop bit leaves half a bit to catch a back-to-back start edge.
        if (cnt_q == CNT_LAST) begin
          cnt_d       = '0;
          stop_sample = 1'b1;
          state_d     = rx_s ? ST_IDLE : ST_WAIT_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_WAIT_IDLE;
      end
    endcase
  end

  always_comb begin
    deliver      = stop_sample & rx_s & ~par_bad;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q & ~rx_if.rx_ready;
    frame_err_d  = stop_sample & ~rx_s;
    parity_err_d = stop_sample & rx_s & par_bad;
    overrun_d    = 1'b0;
    if (deliver) begin
      // A byte leaving on this edge frees the register for the new one.
      if (!rx_valid_q || rx_if.rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  assign rx_if.rx_data    = rx_data_q;
  assign rx_if.rx_valid   = rx_valid_q;
  assign rx_if.frame_err  = frame_err_q;
  assign rx_if.parity_err = parity_err_q;
  assign rx_if.overrun    = overrun_q;

  ap_err_onehot: assert property (@(posedge clock_50_clk) disable iff (reset_reset)
    $onehot0({frame_err_q, parity_err_q, overrun_q}));

  ap_hold_stable: assert property (@(posedge clock_50_clk) disable iff (reset_reset)
    (rx_valid_q && !rx_if.rx_ready) |=> (rx_valid_q && $stable(rx_data_q)));

endmodule

// File: tb/tb_blastit_uart_rx.sv
// Randomized and directed bench for blastit_uart_rx with a scoreboard of expected bytes and error pulses.
`timescale 1ns/1ps
module tb_blastit_uart_rx;
  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
`ifdef BLASTIT_UART_RX_PARITY_EN
  localparam int PAR_EN = 1;
`else
  localparam int PAR_EN = 0;
`endif
  localparam int FRAME_CYC = (10 + PAR_EN) * CPB;
  localparam int LAT       = 3 + HALF + (9 + PAR_EN) * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic uart_rx = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   ready_mode = 0;

  blastit_uart_rx_if rx_if ();

  blastit_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clock_50_clk(clk),
    .reset_reset (rst),
    .uart_rx     (uart_rx),
    .rx_if       (rx_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected bytes and expected error kinds (1 frame, 2 parity, 3 overrun).
  logic [7:0] dataq[$];
  int         errq[$];
  int         xfer_cyc[$];
  int         err_cyc = 0;
  int         n_xfer = 0;
  int         n_err = 0;

  function automatic void check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
    end
  endfunction

  function automatic void check_range(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endfunction

  // Reference model: what one frame on the wire must produce.
  function automatic void expect_frame(input logic [7:0] d, input logic stop_b, input logic par_flip);
    if (!stop_b) errq.push_back(1);
    else if (PAR_EN == 1 && par_flip) errq.push_back(2);
    else dataq.push_back(d);
  endfunction

  task automatic drive_bit(input logic b, input int n);
    uart_rx = b;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip);
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(d[i], CPB);
    if (PAR_EN == 1) drive_bit((^d) ^ par_flip, CPB);
    drive_bit(stop_b, CPB);
  endtask

  task automatic wait_drain(input string name, input int limit);
    int n;
    n = 0;
    while ((dataq.size() != 0 || errq.size() != 0) && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, dataq.size() + errq.size(), 0);
  endtask

  initial begin
    rx_if.rx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       rx_if.rx_ready = 1'b0;
        1:       rx_if.rx_ready = 1'b1;
        default: rx_if.rx_ready = ($urandom_range(0, 1) == 1);
      endcase
    end
  end

  logic       prev_valid = 1'b0;
  logic       prev_xfer = 1'b0;
  logic [7:0] prev_data = 8'h00;
  int         nerr_now;
  int         kind;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
        prev_xfer  = 1'b0;
      end else begin
        if (prev_valid && !prev_xfer) begin
          check("hold_valid", int'(rx_if.rx_valid), 1);
          check("hold_data", int'(rx_if.rx_data), int'(prev_data));
        end
        if (rx_if.rx_valid && rx_if.rx_ready) begin
          n_xfer++;
          xfer_cyc.push_back(cyc);
          if (dataq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_byte: got 0x%0h expected no byte", rx_if.rx_data);
          end else begin
            check("byte", int'(rx_if.rx_data), int'(dataq.pop_front()));
          end
        end
        nerr_now = int'(rx_if.frame_err) + int'(rx_if.parity_err) + int'(rx_if.overrun);
        if (nerr_now > 0) begin
          n_err++;
          err_cyc = cyc;
          kind = rx_if.frame_err ? 1 : (rx_if.parity_err ? 2 : 3);
          check("err_exclusive", nerr_now, 1);
          if (errq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_err: got kind %0d expected none", kind);
          end else begin
            check("err_kind", kind, errq.pop_front());
          end
        end
        prev_valid = rx_if.rx_valid;
        prev_xfer  = rx_if.rx_valid & rx_if.rx_ready;
        prev_data  = rx_if.rx_data;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, n, x0, e0, base;
    logic [7:0] d;
    logic stop_b, pf;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", int'(rx_if.rx_valid), 0);
    check("rst_data", int'(rx_if.rx_data), 0);
    check("rst_errs", int'(rx_if.frame_err) + int'(rx_if.parity_err) + int'(rx_if.overrun), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_bit(1'b1, 4);

    // Single byte: latency and holding until ready.
    ready_mode = 0;
    expect_frame(8'h55, 1'b1, 1'b0);
    t0 = cyc;
    fork
      send_frame(8'h55, 1'b1, 1'b0);
      begin
        n = 0;
        while (!rx_if.rx_valid && n < 400) begin
          @(negedge clk);
          n++;
        end
        check_range("t1_latency", cyc - t0, LAT - 1, LAT + 1);
        check("t1_data", int'(rx_if.rx_data), 8'h55);
      end
    join
    drive_bit(1'b1, 20);
    check("t1_held", int'(rx_if.rx_valid), 1);
    ready_mode = 1;
    @(negedge clk);
    @(negedge clk);
    check("t1_ready_valid", int'(rx_if.rx_valid & rx_if.rx_ready), 1);
    @(negedge clk);
    check("t1_clear", int'(rx_if.rx_valid), 0);
    @(posedge clk);
    #1;

    // Back-to-back frames with no idle gap.
    base = xfer_cyc.size();
    e0 = n_err;
    expect_frame(8'hA5, 1'b1, 1'b0);
    expect_frame(8'h3C, 1'b1, 1'b0);
    send_frame(8'hA5, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0);
    drive_bit(1'b1, 2 * CPB);
    check("t2_count", xfer_cyc.size() - base, 2);
    if (xfer_cyc.size() >= base + 2)
      check_range("t2_spacing", xfer_cyc[base+1] - xfer_cyc[base], FRAME_CYC - 1, FRAME_CYC + 1);
    check("t2_no_err", n_err - e0, 0);

    // Overrun: second byte dropped, first retained.
    ready_mode = 0;
    drive_bit(1'b1, 4);
    x0 = n_xfer;
    expect_frame(8'h12, 1'b1, 1'b0);
    errq.push_back(3);
    send_frame(8'h12, 1'b1, 1'b0);
    send_frame(8'h34, 1'b1, 1'b0);
    drive_bit(1'b1, 20);
    check("t3_valid", int'(rx_if.rx_valid), 1);
    check("t3_data", int'(rx_if.rx_data), 8'h12);
    ready_mode = 1;
    drive_bit(1'b1, 20);
    check("t3_one_xfer", n_xfer - x0, 1);
    check("t3_err_seen", errq.size(), 0);

    // Framing error with line held low, then recovery.
    x0 = n_xfer;
    e0 = n_err;
    expect_frame(8'hF0, 1'b0, 1'b0);
    t0 = cyc;
    send_frame(8'hF0, 1'b0, 1'b0);
    drive_bit(1'b0, 40);
    check("t4_err_count", n_err - e0, 1);
    check_range("t4_err_time", err_cyc - t0, LAT - 1, LAT + 1);
    check("t4_no_xfer", n_xfer - x0, 0);
    check("t4_valid_low", int'(rx_if.rx_valid), 0);
    drive_bit(1'b1, 20);
    expect_frame(8'h0F, 1'b1, 1'b0);
    send_frame(8'h0F, 1'b1, 1'b0);
    drive_bit(1'b1, CPB);
    wait_drain("t4_drain", 500);

    // Short glitch is ignored.
    x0 = n_xfer;
    e0 = n_err;
    drive_bit(1'b0, 5);
    drive_bit(1'b1, 3 * CPB);
    check("t5_glitch_xfer", n_xfer - x0, 0);
    check("t5_glitch_err", n_err - e0, 0);
    check("t5_glitch_valid", int'(rx_if.rx_valid), 0);

    // Reset mid-frame clears a held byte and the partial frame.
    ready_mode = 0;
    drive_bit(1'b1, 4);
    send_frame(8'h99, 1'b1, 1'b0);
    drive_bit(1'b1, CPB);
    check("t5_pre_valid", int'(rx_if.rx_valid), 1);
    d = 8'h81;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_bit(d[i], CPB);
    drive_bit(d[4], HALF);
    rst = 1'b1;
    @(posedge clk);
    #1;
    uart_rx = 1'b1;
    @(negedge clk);
    check("t5_rst_valid", int'(rx_if.rx_valid), 0);
    check("t5_rst_data", int'(rx_if.rx_data), 0);
    check("t5_rst_errs", int'(rx_if.frame_err) + int'(rx_if.parity_err) + int'(rx_if.overrun), 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    x0 = n_xfer;
    e0 = n_err;
    drive_bit(1'b1, 2 * CPB);
    check("t5_post_valid", int'(rx_if.rx_valid), 0);
    check("t5_post_err", n_err - e0, 0);
    ready_mode = 1;
    expect_frame(8'h7E, 1'b1, 1'b0);
    send_frame(8'h7E, 1'b1, 1'b0);
    drive_bit(1'b1, CPB);
    wait_drain("t5_drain", 500);
    check("t5_one_xfer", n_xfer - x0, 1);

`ifdef BLASTIT_UART_RX_PARITY_EN
    // Parity: correct even parity delivered, flipped parity rejected.
    x0 = n_xfer;
    expect_frame(8'h07, 1'b1, 1'b0);
    send_frame(8'h07, 1'b1, 1'b0);
    expect_frame(8'h07, 1'b1, 1'b1);
    send_frame(8'h07, 1'b1, 1'b1);
    drive_bit(1'b1, CPB);
    wait_drain("t6_drain", 500);
    check("t6_one_xfer", n_xfer - x0, 1);
`endif

    // Random frames, random gaps, random stop/parity faults, random ready.
    ready_mode = 2;
    for (int f = 0; f < 30; f++) begin
      d      = 8'($urandom);
      stop_b = ($urandom_range(0, 4) != 0);
      pf     = ($urandom_range(0, 3) == 0);
      expect_frame(d, stop_b, pf);
      send_frame(d, stop_b, pf);
      if (!stop_b) begin
        drive_bit(1'b0, $urandom_range(0, 20));
        drive_bit(1'b1, 4 + $urandom_range(0, 20));
      end else begin
        drive_bit(1'b1, $urandom_range(0, 20));
      end
    end
    drive_bit(1'b1, CPB);
    ready_mode = 1;
    wait_drain("rand_drain", 2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/blastit_uart_rx.md
# blastit_uart_rx

Receive-side UART for blastit: deserializes 8-bit frames arriving on the board `UART_RX` pin (synchronized internally) and presents each byte to the controller fabric through a single-entry valid/ready holding register. It is the receive-direction counterpart of the controller's transmit path on `UART_TX`. The block also flags framing errors and overruns, and optionally parity errors.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per bit (50 MHz / 115200). Legal range is ≥ 4.
- `clock_50_clk`  in  1  system clock, 50 MHz.
- `reset_reset`  in  1  reset, **synchronous, active-high**.
- `uart_rx`  in  1  raw serial line, idle high, asynchronous to the clock.
- `rx_data`  out  8  received byte, LSB first on the wire. Stable while `rx_valid` is high.
- `rx_valid`  out  1  byte available.
- `rx_ready`  in  1  consumer accepts the byte.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `parity_err`  out  1  one-cycle pulse: parity mismatch. Tied 0 when parity is compiled out.
- `overrun`  out  1  one-cycle pulse: a new byte was dropped because the holding register was full.

## Operation
- **Synchronizer:** 2 flops on `uart_rx`, both reset to 1. Output `rx_s`.
- **Bit counter:** `cnt`, width `$clog2(CLKS_PER_BIT)`. `HALF = CLKS_PER_BIT/2` (integer division).
- **States:** WAIT_IDLE, IDLE, START, DATA, [PARITY], STOP.
  - **WAIT_IDLE** (reset state): go to IDLE when `rx_s`=1.
  - **IDLE:** when `rx_s`=0, go to START with `cnt`=0.
  - **START:** increment `cnt`. At `cnt`=HALF-1, sample `rx_s`:
    - 0: go to DATA with `cnt`=0 and bit index 0.
    - 1: glitch. Return to IDLE with no output.
  - **DATA:** at `cnt`=CLKS_PER_BIT-1, shift `rx_s` into the shift register (right-shift, LSB first) and set `cnt`=0. After bit 7, go to PARITY (if enabled) or STOP.
  - **PARITY:** at `cnt`=CLKS_PER_BIT-1, sample the parity bit and go to STOP.
  - **STOP:** at `cnt`=CLKS_PER_BIT-1, sample `rx_s`:
    - 1 and no parity error: deliver the byte and go to IDLE.
    - 1 with parity error: pulse `parity_err`, discard the byte, go to IDLE.
    - 0: pulse `frame_err`, discard the byte, go to WAIT_IDLE. A break or line held low never produces a byte.
- **Delivery:**
  - Holding empty, or `rx_valid`&`rx_ready` in the same cycle: load `rx_data` and set `rx_valid`=1 on the next edge.
  - Otherwise: pulse `overrun`. The old byte is retained and the new byte is dropped.
- **Handshake:** a transfer occurs on any edge with `rx_valid`&`rx_ready`. `rx_valid` clears after the transfer unless a delivery happens in the same cycle, in which case it stays 1 with the new data.
- **Error exclusivity:** the error pulses are mutually exclusive, at most one per frame.
- **Reset mid-frame:** abort immediately to WAIT_IDLE and discard the partial byte. The holding register clears.

## Timing
- **Reset values:** `rx_data`=0x00, `rx_valid`=0, `frame_err`=0, `parity_err`=0, `overrun`=0, state WAIT_IDLE, sync flops 1.
- **Latency:** from the start-bit falling edge on `uart_rx` to `rx_valid` rising:
  - 3 + HALF + 9·CLKS_PER_BIT cycles, ±1 for sampling phase.
  - Add CLKS_PER_BIT when parity is enabled.
  - Error pulses occur in the cycle where `rx_valid` would have risen.
- **Sample point:** mid-bit, within ±1 cycle of nominal.
- **Frame rate:** back-to-back frames with zero idle between them are received without loss. The block returns to IDLE at mid-stop-bit.
- **Input combinational paths:** none. `rx_ready` only affects the next-edge state.

## Configuration
- **`BLASTIT_UART_RX_PARITY_EN` defined:**
  - Frame is start + 8 data + even parity + stop (11 bits).
  - PARITY state is present.
  - `parity_err` pulses when the XOR of the 8 data bits and the parity bit is 1.
- **Undefined:**
  - Frame is 8N1 (10 bits).
  - No PARITY state.
  - `parity_err` is constant 0.

## Test plan
- **Single byte:** with `CLKS_PER_BIT`=16 and `rx_ready`=0, send 0x55 8N1. Expect `rx_valid`=1, `rx_data`=0x55 at 3+8+144 ±1 cycles, held until `rx_ready`=1, then `rx_valid`=0 on the next edge.
- **Back-to-back:** send 0xA5 then 0x3C with no idle gap, `rx_ready`=1. Expect two transfers, 0xA5 then 0x3C, 160 ±1 cycles apart, with no error pulses.
- **Overrun:** send 0x12 then 0x34 with `rx_ready`=0. Expect an `overrun` pulse of 1 cycle at the second delivery and `rx_data` still 0x12. After raising `rx_ready`, exactly one transfer of 0x12 occurs.
- **Framing error and recovery:**
  - Send 0xF0 with the stop bit driven 0 and the line held low for 40 cycles: expect one `frame_err` pulse and `rx_valid` staying 0.
  - Release the line and send 0x0F: expect `rx_data`=0x0F.
- **Glitch and reset:**
  - A 5-cycle low glitch produces no output.
  - Assert `reset_reset` during bit 4 of 0x81, then send 0x7E: expect only 0x7E delivered and all outputs 0 during reset.
- **Parity (macro defined):**
  - 0x07 with parity bit 1 is delivered.
  - 0x07 with parity bit 0 gives a `parity_err` pulse and no `rx_valid`.
